// File: rtl/circuit4_sweep_ctrl_if.sv
// Interface between the circuit4 sweep sequencer and its host/DUT.
//   start, abort     : host controls of the sweep
//   y_i              : circuit4 outputs {Y2,Y1,Y0}
//   abcd_o           : circuit4 inputs {A,B,C,D}, A = bit 3
//   busy, done, pass : sweep status
//   err_cnt          : number of mismatching vectors (0..16)
//   first_err_valid  : a mismatch was seen this sweep
//   first_err_vec    : abcd_o of the first mismatch
// slave modport is taken by the sequencer, master by whoever drives it.
interface circuit4_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic [2:0] y_i;
  logic [3:0] abcd_o;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic       first_err_valid;
  logic [3:0] first_err_vec;

  modport master (
    output start, abort, y_i,
    input  abcd_o, busy, done, pass, err_cnt, first_err_valid, first_err_vec
  );

  modport slave (
    input  start, abort, y_i,
    output abcd_o, busy, done, pass, err_cnt, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/circuit4_sweep_ctrl.sv
// Self-checking sweep sequencer for circuit4 (4-input ones counter).
// On start it applies vectors 0000..1111 in order, holds each SETTLE_CYC cycles, then compares
// y_i with the popcount of the vector and accumulates the error count, the first failing vector
// and an overall pass flag.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset; clears all outputs and returns to idle
//   bus    : circuit4_sweep_ctrl_if.slave (start/abort/y_i in, abcd_o and status out)
// All outputs are registered.
module circuit4_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 2  // legal 1..255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  circuit4_sweep_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [7:0] Reload = 8'(SETTLE_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] abcd_q, abcd_d;
  logic [4:0] err_q, err_d;
  logic       fev_q, fev_d;
  logic [3:0] fvec_q, fvec_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [2:0] exp_y;
  logic       mismatch;
  logic [4:0] err_next;

  assign exp_y    = 3'(abcd_q[3]) + 3'(abcd_q[2]) + 3'(abcd_q[1]) + 3'(abcd_q[0]);
  assign mismatch = (bus.y_i != exp_y);
  assign err_next = err_q + 5'(mismatch);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abcd_d  = abcd_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;
    pass_d  = pass_q;

    unique case (state_q)
      StIdle: begin
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          abcd_d  = 4'h0;
          cnt_d   = Reload;
          err_d   = 5'd0;
          fev_d   = 1'b0;
          fvec_d  = 4'h0;
          pass_d  = 1'b0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StCheck: begin
        if (bus.abort) begin
          pass_d  = 1'b0;
          state_d = StIdle;
        end else begin
          if (mismatch) begin
            err_d = err_next;
            if (!fev_q) begin
              fev_d  = 1'b1;
              fvec_d = abcd_q;
            end
          end
          if (abcd_q == 4'hF) begin
            pass_d  = (err_next == 5'd0);
            state_d = StDone;
          end else begin
            abcd_d  = abcd_q + 4'h1;
            cnt_d   = Reload;
            state_d = StSettle;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StSettle) || (state_d == StCheck);
    // done registers the DONE state, so the pulse follows one edge after entering DONE
    done_d = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      abcd_q  <= 4'h0;
      err_q   <= 5'd0;
      fev_q   <= 1'b0;
      fvec_q  <= 4'h0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.abcd_o          = abcd_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_vec   = fvec_q;

endmodule

// File: tb/tb_circuit4_sweep_ctrl.sv
// Bench for circuit4_sweep_ctrl: two instances (SETTLE_CYC=2 and 1), a behavioural circuit4
// model with fault modes, a stimulus process pushing expected sweep results, and monitors that
// pop and compare on each done pulse.
module tb_circuit4_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  circuit4_sweep_ctrl_if b1 ();
  circuit4_sweep_ctrl_if b2 ();

  circuit4_sweep_ctrl #(.SETTLE_CYC(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  circuit4_sweep_ctrl #(.SETTLE_CYC(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  // circuit4 model: 0 golden, 1 y=0 for vector 6, 2 stuck at 0
  int mode1 = 0;

  function automatic logic [2:0] popc(input logic [3:0] v);
    return 3'(v[3]) + 3'(v[2]) + 3'(v[1]) + 3'(v[0]);
  endfunction

  always_comb begin
    b1.y_i = popc(b1.abcd_o);
    if (mode1 == 2 || (mode1 == 1 && b1.abcd_o == 4'h6)) b1.y_i = 3'b000;
    b2.y_i = popc(b2.abcd_o);
  end

  typedef struct {
    int pass;
    int err;
    int fev;
    int fvec;
    int lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   start_cyc1 = 0;
  int   start_cyc2 = 0;
  int   done_cnt1 = 0;
  int   done_cnt2 = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare a result whenever a DUT presents done.
  always @(negedge clk) begin
    if (b1.done) begin
      chk("dut1_done_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_latency", cyc - start_cyc1 - 1, e.lat);
        chk("dut1_pass", int'(b1.pass), e.pass);
        chk("dut1_err_cnt", int'(b1.err_cnt), e.err);
        chk("dut1_first_err_valid", int'(b1.first_err_valid), e.fev);
        chk("dut1_first_err_vec", int'(b1.first_err_vec), e.fvec);
        chk("dut1_busy_at_done", int'(b1.busy), 0);
      end
      done_cnt1++;
    end
    if (b2.done) begin
      chk("dut2_done_expected", int'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_latency", cyc - start_cyc2 - 1, e.lat);
        chk("dut2_pass", int'(b2.pass), e.pass);
        chk("dut2_err_cnt", int'(b2.err_cnt), e.err);
        chk("dut2_first_err_valid", int'(b2.first_err_valid), e.fev);
      end
      done_cnt2++;
    end
  end

  task automatic start1(input int m);
    @(negedge clk);
    mode1      = m;
    start_cyc1 = cyc;
    b1.start   = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
  endtask

  task automatic push1(input int p, input int e, input int fv, input int vec, input int lat);
    exp_t x;
    x.pass = p; x.err = e; x.fev = fv; x.fvec = vec; x.lat = lat;
    q1.push_back(x);
  endtask

  task automatic wait_done1(input int budget);
    int n0;
    int got;
    n0  = done_cnt1;
    got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (done_cnt1 != n0) got = 1;
    end
    chk("dut1_done_seen", got, 1);
  endtask

  task automatic wait_vec1(input logic [3:0] v);
    int got;
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      @(negedge clk);
      if (b1.abcd_o == v && b1.busy) got = 1;
    end
    chk("dut1_reached_vector", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    b1.start = 1'b0; b1.abort = 1'b0;
    b2.start = 1'b0; b2.abort = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_abcd", int'(b1.abcd_o), 0);
    chk("rst_busy", int'(b1.busy), 0);
    chk("rst_done", int'(b1.done), 0);
    chk("rst_pass", int'(b1.pass), 0);
    chk("rst_err_cnt", int'(b1.err_cnt), 0);
    chk("rst_fev", int'(b1.first_err_valid), 0);
    chk("rst_fvec", int'(b1.first_err_vec), 0);

    // 1: golden sweep
    push1(1, 0, 0, 0, 49);
    start1(0);
    chk("t1_busy_after_start", int'(b1.busy), 1);
    wait_done1(80);
    repeat (3) @(negedge clk);
    chk("t1_pass_held", int'(b1.pass), 1);
    chk("t1_abcd_last", int'(b1.abcd_o), 15);

    // 2: single fault at vector 6
    push1(0, 1, 1, 6, 49);
    start1(1);
    wait_done1(80);

    // 3: stuck at zero
    push1(0, 15, 1, 1, 49);
    start1(2);
    chk("t3_pass_cleared_on_start", int'(b1.pass), 0);
    wait_done1(80);

    // 4: abort at vector 9 (stuck model so partial results are visible), no done expected
    start1(2);
    wait_vec1(4'h9);
    b1.abort = 1'b1;
    @(negedge clk);
    b1.abort = 1'b0;
    chk("t4_busy", int'(b1.busy), 0);
    chk("t4_abcd_kept", int'(b1.abcd_o), 9);
    chk("t4_err_partial", int'(b1.err_cnt), 8);
    chk("t4_fvec_partial", int'(b1.first_err_vec), 1);
    chk("t4_pass", int'(b1.pass), 0);
    repeat (60) @(negedge clk);
    chk("t4_still_idle", int'(b1.busy), 0);
    // start with abort in idle: abort wins
    b1.start = 1'b1; b1.abort = 1'b1;
    @(negedge clk);
    b1.start = 1'b0; b1.abort = 1'b0;
    chk("t4_start_abort_idle", int'(b1.busy), 0);
    push1(1, 0, 0, 0, 49);
    start1(0);
    chk("t4_restart_abcd0", int'(b1.abcd_o), 0);
    chk("t4_restart_err_clear", int'(b1.err_cnt), 0);
    wait_done1(80);

    // 5: async reset at vector 5
    start1(2);
    wait_vec1(4'h5);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_abcd", int'(b1.abcd_o), 0);
    chk("t5_busy", int'(b1.busy), 0);
    chk("t5_err_cnt", int'(b1.err_cnt), 0);
    chk("t5_fev", int'(b1.first_err_valid), 0);
    chk("t5_fvec", int'(b1.first_err_vec), 0);
    chk("t5_pass", int'(b1.pass), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push1(1, 0, 0, 0, 49);
    start1(0);
    wait_done1(80);

    // 6: SETTLE_CYC=1 instance, start re-pulsed while busy
    begin
      exp_t x;
      int   n0;
      int   got;
      x.pass = 1; x.err = 0; x.fev = 0; x.fvec = 0; x.lat = 33;
      q2.push_back(x);
      n0 = done_cnt2;
      got = 0;
      @(negedge clk);
      start_cyc2 = cyc;
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      for (int i = 0; i < 60 && got == 0; i++) begin
        b2.start = (i == 4 || i == 11 || i == 20 || i == 29);
        @(negedge clk);
        if (done_cnt2 != n0) got = 1;
      end
      b2.start = 1'b0;
      chk("dut2_done_seen", got, 1);
    end

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
